// File: rtl/conv_cfg_sequencer_if.sv
// Host request channel plus the LTC2195/AD9783 driver command ports of conv_cfg_sequencer.
// master = sequencer side, slave = top-level / driver side.
interface conv_cfg_sequencer_if;
  logic        host_req_in;
  logic        host_tgt_in;
  logic [15:0] host_addr_in;
  logic [15:0] host_data_in;
  logic        host_ack_out;
  logic        busy_out;
  logic        init_done_out;
  logic        err_out;
  logic        adc_cmd_trig_out;
  logic [15:0] adc_cmd_addr_out;
  logic [15:0] adc_cmd_data_out;
  logic        dac_cmd_trig_out;
  logic [15:0] dac_cmd_addr_out;
  logic [15:0] dac_cmd_data_out;
  logic [15:0] dac_cmd_data_in;

  modport master (
    input  host_req_in, host_tgt_in, host_addr_in, host_data_in, dac_cmd_data_in,
    output host_ack_out, busy_out, init_done_out, err_out,
    output adc_cmd_trig_out, adc_cmd_addr_out, adc_cmd_data_out,
    output dac_cmd_trig_out, dac_cmd_addr_out, dac_cmd_data_out
  );

  modport slave (
    output host_req_in, host_tgt_in, host_addr_in, host_data_in, dac_cmd_data_in,
    input  host_ack_out, busy_out, init_done_out, err_out,
    input  adc_cmd_trig_out, adc_cmd_addr_out, adc_cmd_data_out,
    input  dac_cmd_trig_out, dac_cmd_addr_out, dac_cmd_data_out
  );
endinterface

// File: rtl/conv_cfg_sequencer.sv
// Plays a fixed LTC2195/AD9783 SPI init table after reset, then arbitrates host writes onto the
// shared driver command ports. Define CFG_READBACK_EN to verify every DAC write by readback.
module conv_cfg_sequencer #(
  parameter int unsigned STARTUP_DLY = 1000,
  parameter int unsigned SPI_WAIT    = 2000,
  parameter int unsigned N_INIT      = 4
) (
  input logic                  clk_in,
  input logic                  rst_in,
  conv_cfg_sequencer_if.master bus
);
  localparam int unsigned WaitW = $clog2(SPI_WAIT + 1);
  localparam int unsigned DlyW  = $clog2(STARTUP_DLY + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(SPI_WAIT - 1);
  localparam logic [DlyW-1:0]  DlyLast  = DlyW'(STARTUP_DLY - 1);
  localparam logic [3:0]       IdxLast  = 4'(N_INIT - 1);

  typedef enum logic [2:0] {
    StStart,
    StIssue,
    StWait,
    StAck,
    StReady
`ifdef CFG_READBACK_EN
    ,
    StRdIssue,
    StRdWait,
    StCheck
`endif
  } state_e;

  typedef struct packed {
    logic        tgt;  // 0 = ADC, 1 = DAC
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  function automatic cmd_t init_entry(input logic [3:0] idx);
    cmd_t e;
    e = '{tgt: 1'b0, addr: 16'h0000, data: 16'h0000};
    case (idx)
      4'd0: e.data = 16'h0080;
      4'd1: e.addr = 16'h0002;
      4'd2: begin
        e.tgt  = 1'b1;
        e.data = 16'h0020;
      end
      4'd3: begin
        e.tgt  = 1'b1;
        e.addr = 16'h0002;
      end
      default: ;
    endcase
    return e;
  endfunction

  state_e           state_q, state_d;
  logic [DlyW-1:0]  dly_q, dly_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [3:0]       idx_q, idx_d;
  cmd_t             cmd_q, cmd_d;
  logic             init_done_q, init_done_d;
  logic [15:0]      adc_addr_q, adc_addr_d, adc_data_q, adc_data_d;
  logic [15:0]      dac_addr_q, dac_addr_d, dac_data_q, dac_data_d;
  logic             cmd_done;
`ifdef CFG_READBACK_EN
  logic             err_q, err_d;
`else
  logic             unused_rd;
  assign unused_rd = ^bus.dac_cmd_data_in;
`endif

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    wait_d      = wait_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    init_done_d = init_done_q;
    cmd_done    = 1'b0;
`ifdef CFG_READBACK_EN
    err_d       = err_q;
`endif
    case (state_q)
      StStart: begin
        if (dly_q == DlyLast) begin
          idx_d   = 4'd0;
          cmd_d   = init_entry(4'd0);
          state_d = StIssue;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end
      StIssue: begin
        wait_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        if (wait_q == WaitLast) begin
          wait_d = '0;
`ifdef CFG_READBACK_EN
          if (cmd_q.tgt) state_d = StRdIssue;
          else           cmd_done = 1'b1;
`else
          cmd_done = 1'b1;
`endif
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StReady: begin
        if (bus.host_req_in) begin
          cmd_d   = '{tgt: bus.host_tgt_in, addr: bus.host_addr_in, data: bus.host_data_in};
          state_d = StIssue;
        end
      end
      StAck: state_d = StReady;
`ifdef CFG_READBACK_EN
      StRdIssue: begin
        wait_d  = '0;
        state_d = StRdWait;
      end
      StRdWait: begin
        if (wait_q == WaitLast) begin
          wait_d  = '0;
          state_d = StCheck;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCheck: begin
        if (bus.dac_cmd_data_in[7:0] != cmd_q.data[7:0]) err_d = 1'b1;
        cmd_done = 1'b1;
      end
`endif
      default: state_d = StStart;
    endcase

    // A finished command either advances the init table or, once init is over, acks the host.
    if (cmd_done) begin
      if (init_done_q) begin
        state_d = StAck;
      end else if (idx_q == IdxLast) begin
        init_done_d = 1'b1;
        state_d     = StReady;
      end else begin
        idx_d   = idx_q + 4'd1;
        cmd_d   = init_entry(idx_q + 4'd1);
        state_d = StIssue;
      end
    end
  end

  // Command ports only change when a new strobe is about to go out.
  always_comb begin
    adc_addr_d = adc_addr_q;
    adc_data_d = adc_data_q;
    dac_addr_d = dac_addr_q;
    dac_data_d = dac_data_q;
    if (state_d == StIssue) begin
      if (cmd_d.tgt) begin
        dac_addr_d = cmd_d.addr;
        dac_data_d = cmd_d.data;
      end else begin
        adc_addr_d = cmd_d.addr;
        adc_data_d = cmd_d.data;
      end
    end
`ifdef CFG_READBACK_EN
    if (state_d == StRdIssue) dac_addr_d = cmd_q.addr | 16'h8000;
`endif
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= StStart;
      dly_q       <= '0;
      wait_q      <= '0;
      idx_q       <= 4'd0;
      cmd_q       <= '0;
      init_done_q <= 1'b0;
      adc_addr_q  <= 16'h0000;
      adc_data_q  <= 16'h0000;
      dac_addr_q  <= 16'h0000;
      dac_data_q  <= 16'h0000;
`ifdef CFG_READBACK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dly_q       <= dly_d;
      wait_q      <= wait_d;
      idx_q       <= idx_d;
      cmd_q       <= cmd_d;
      init_done_q <= init_done_d;
      adc_addr_q  <= adc_addr_d;
      adc_data_q  <= adc_data_d;
      dac_addr_q  <= dac_addr_d;
      dac_data_q  <= dac_data_d;
`ifdef CFG_READBACK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.adc_cmd_trig_out = (state_q == StIssue) && !cmd_q.tgt;
`ifdef CFG_READBACK_EN
  assign bus.dac_cmd_trig_out = ((state_q == StIssue) && cmd_q.tgt) || (state_q == StRdIssue);
  assign bus.err_out          = err_q;
`else
  assign bus.dac_cmd_trig_out = (state_q == StIssue) && cmd_q.tgt;
  assign bus.err_out          = 1'b0;
`endif
  assign bus.adc_cmd_addr_out = adc_addr_q;
  assign bus.adc_cmd_data_out = adc_data_q;
  assign bus.dac_cmd_addr_out = dac_addr_q;
  assign bus.dac_cmd_data_out = dac_data_q;
  assign bus.host_ack_out     = (state_q == StAck);
  assign bus.busy_out         = (state_q != StReady);
  assign bus.init_done_out    = init_done_q;

endmodule

// File: tb/tb_conv_cfg_sequencer.sv
// Directed bench for conv_cfg_sequencer with STARTUP_DLY=10, SPI_WAIT=20; cycle k counts
// posedges after reset release, outputs sampled on the following negedge.
module tb_conv_cfg_sequencer;
  localparam int unsigned StartupDly = 10;
  localparam int unsigned SpiWait    = 20;
`ifdef CFG_READBACK_EN
  localparam int DacLen = 43;  // write 21 + read strobe 1 + read wait 20 + check 1
  localparam int RdPer  = 1;
`else
  localparam int DacLen = 21;
  localparam int RdPer  = 0;
`endif
  localparam int DoneK = 52 + 2 * DacLen;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  conv_cfg_sequencer_if bus ();

  // DAC driver model: echoes the written data unless a readback value is forced.
  logic        rb_force = 1'b0;
  logic [15:0] rb_val   = 16'h0000;
  assign bus.dac_cmd_data_in = rb_force ? rb_val : bus.dac_cmd_data_out;

  conv_cfg_sequencer #(
    .STARTUP_DLY(StartupDly),
    .SPI_WAIT   (SpiWait),
    .N_INIT     (4)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  int          k_log[$];
  logic        tgt_log[$];
  logic [15:0] addr_log[$];
  logic [15:0] data_log[$];
  int          ack_log[$];
  int          rd_cnt, done_at, busy_fall_at, both_trig;

  task clear_logs();
    k_log.delete(); tgt_log.delete(); addr_log.delete(); data_log.delete(); ack_log.delete();
    rd_cnt = 0; done_at = -1; busy_fall_at = -1; both_trig = 0;
  endtask

  // Steps n cycles (numbered k0+1..k0+n) and logs strobes, acks and status edges.
  task run(input int n, input bit drop_on_ack, input int k0);
    for (int k = k0 + 1; k <= k0 + n; k++) begin
      @(posedge clk_in);
      @(negedge clk_in);
      if (bus.adc_cmd_trig_out && bus.dac_cmd_trig_out) both_trig++;
      if (bus.adc_cmd_trig_out) begin
        k_log.push_back(k); tgt_log.push_back(1'b0);
        addr_log.push_back(bus.adc_cmd_addr_out); data_log.push_back(bus.adc_cmd_data_out);
      end
      if (bus.dac_cmd_trig_out) begin
        if (bus.dac_cmd_addr_out[15]) rd_cnt++;
        else begin
          k_log.push_back(k); tgt_log.push_back(1'b1);
          addr_log.push_back(bus.dac_cmd_addr_out); data_log.push_back(bus.dac_cmd_data_out);
        end
      end
      if (bus.host_ack_out) begin
        ack_log.push_back(k);
        if (drop_on_ack) bus.host_req_in = 1'b0;
      end
      if (bus.init_done_out && done_at < 0) done_at = k;
      if (!bus.busy_out && busy_fall_at < 0) busy_fall_at = k;
    end
  endtask

  task set_req(input logic tgt, input logic [15:0] addr, input logic [15:0] data);
    bus.host_req_in  = 1'b1;
    bus.host_tgt_in  = tgt;
    bus.host_addr_in = addr;
    bus.host_data_in = data;
  endtask

  task test_reset();
    logic [69:0] obs, exp_v;
    rst_in = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
    obs = {bus.host_ack_out, bus.busy_out, bus.init_done_out, bus.err_out, bus.adc_cmd_trig_out,
           bus.dac_cmd_trig_out, bus.adc_cmd_addr_out, bus.adc_cmd_data_out,
           bus.dac_cmd_addr_out, bus.dac_cmd_data_out};
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++; $display("FAIL reset_state: got %h want %h", obs, exp_v);
    end
    tests_run++;
    if (bus.err_out !== 1'b0) begin
      tests_failed++; $display("FAIL reset_err: got %b want 0", bus.err_out);
    end
    rst_in = 1'b0;
  endtask

  task test_init();
    int          exp_k[4];
    logic        exp_tgt[4];
    logic [15:0] exp_addr[4], exp_data[4];
    exp_k    = '{10, 31, 52, 52 + DacLen};
    exp_tgt  = '{1'b0, 1'b0, 1'b1, 1'b1};
    exp_addr = '{16'h0000, 16'h0002, 16'h0000, 16'h0002};
    exp_data = '{16'h0080, 16'h0000, 16'h0020, 16'h0000};
    clear_logs();
    run(DoneK + 6, 1'b0, 0);
    tests_run++;
    if (k_log.size() !== 4) begin
      tests_failed++; $display("FAIL init_count: got %0d want 4", k_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (k_log[i] !== exp_k[i] || tgt_log[i] !== exp_tgt[i] || addr_log[i] !== exp_addr[i] ||
          data_log[i] !== exp_data[i]) begin
        tests_failed++;
        $display("FAIL init_entry%0d: got k=%0d tgt=%b %h/%h want k=%0d tgt=%b %h/%h", i,
                 k_log[i], tgt_log[i], addr_log[i], data_log[i], exp_k[i], exp_tgt[i],
                 exp_addr[i], exp_data[i]);
      end
    end
    tests_run++;
    if (done_at !== DoneK) begin
      tests_failed++; $display("FAIL init_done_cycle: got %0d want %0d", done_at, DoneK);
    end
    tests_run++;
    if (busy_fall_at !== DoneK) begin
      tests_failed++; $display("FAIL busy_fall_cycle: got %0d want %0d", busy_fall_at, DoneK);
    end
    tests_run++;
    if (both_trig !== 0 || rd_cnt !== 2 * RdPer) begin
      tests_failed++;
      $display("FAIL init_strobes: both=%0d rd=%0d want 0 and %0d", both_trig, rd_cnt, 2 * RdPer);
    end
  endtask

  task test_host_write();
    clear_logs();
    set_req(1'b1, 16'h0014, 16'h00AB);
    run(DacLen + 10, 1'b1, 0);
    tests_run++;
    if (k_log.size() !== 1 || k_log[0] !== 1 || tgt_log[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL host_trig: got n=%0d k=%0d tgt=%b want n=1 k=1 tgt=1", k_log.size(),
               k_log[0], tgt_log[0]);
    end
    tests_run++;
    if (addr_log[0] !== 16'h0014 || data_log[0] !== 16'h00AB) begin
      tests_failed++;
      $display("FAIL host_cmd: got %h/%h want 0014/00ab", addr_log[0], data_log[0]);
    end
    tests_run++;
    if (ack_log.size() !== 1 || ack_log[0] !== 1 + DacLen) begin
      tests_failed++;
      $display("FAIL host_ack: got n=%0d k=%0d want n=1 k=%0d", ack_log.size(), ack_log[0],
               1 + DacLen);
    end
    tests_run++;
    if (bus.busy_out !== 1'b0 || rd_cnt !== RdPer) begin
      tests_failed++;
      $display("FAIL host_end: busy=%b rd=%0d want 0 and %0d", bus.busy_out, rd_cnt, RdPer);
    end
  endtask

  task test_req_during_init();
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    set_req(1'b0, 16'h0033, 16'h1234);
    clear_logs();
    run(DoneK + 30, 1'b1, 0);
    tests_run++;
    if (k_log.size() !== 5) begin
      tests_failed++; $display("FAIL pend_count: got %0d want 5", k_log.size());
    end
    tests_run++;
    if (k_log[3] !== 52 + DacLen || addr_log[3] !== 16'h0002 || tgt_log[3] !== 1'b1) begin
      tests_failed++;
      $display("FAIL pend_init3: got k=%0d %h want k=%0d 0002", k_log[3], addr_log[3],
               52 + DacLen);
    end
    tests_run++;
    if (k_log[4] !== DoneK + 1 || tgt_log[4] !== 1'b0 || addr_log[4] !== 16'h0033 ||
        data_log[4] !== 16'h1234) begin
      tests_failed++;
      $display("FAIL pend_host: got k=%0d tgt=%b %h/%h want k=%0d tgt=0 0033/1234", k_log[4],
               tgt_log[4], addr_log[4], data_log[4], DoneK + 1);
    end
    tests_run++;
    if (ack_log.size() !== 1 || ack_log[0] !== DoneK + 22) begin
      tests_failed++;
      $display("FAIL pend_ack: got n=%0d k=%0d want n=1 k=%0d", ack_log.size(), ack_log[0],
               DoneK + 22);
    end
  endtask

  task test_reset_mid();
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    clear_logs();
    run(60, 1'b0, 0);
    tests_run++;
    if (k_log.size() !== 3 || bus.dac_cmd_data_out !== 16'h0020) begin
      tests_failed++;
      $display("FAIL mid_pre: got n=%0d dac_data=%h want n=3 0020", k_log.size(),
               bus.dac_cmd_data_out);
    end
    rst_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    tests_run++;
    if (bus.dac_cmd_trig_out !== 1'b0 || bus.init_done_out !== 1'b0 || bus.busy_out !== 1'b1 ||
        bus.dac_cmd_data_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL mid_reset: trig=%b done=%b busy=%b data=%h want 0 0 1 0000",
               bus.dac_cmd_trig_out, bus.init_done_out, bus.busy_out, bus.dac_cmd_data_out);
    end
    rst_in = 1'b0;
    clear_logs();
    run(40, 1'b0, 0);
    tests_run++;
    if (k_log.size() !== 2 || k_log[0] !== 10 || tgt_log[0] !== 1'b0 ||
        data_log[0] !== 16'h0080 || k_log[1] !== 31) begin
      tests_failed++;
      $display("FAIL mid_replay: got n=%0d k0=%0d data0=%h k1=%0d want 2 10 0080 31",
               k_log.size(), k_log[0], data_log[0], k_log[1]);
    end
    run(2 * DacLen + 20, 1'b0, 40);
    tests_run++;
    if (bus.init_done_out !== 1'b1) begin
      tests_failed++; $display("FAIL mid_done: got %b want 1", bus.init_done_out);
    end
  endtask

  task test_back_to_back();
    clear_logs();
    set_req(1'b1, 16'h0005, 16'h0011);
    run(DacLen + 13, 1'b0, 0);
    bus.host_req_in = 1'b0;
    run(DacLen + 10, 1'b0, DacLen + 13);
    tests_run++;
    if (k_log.size() !== 2 || k_log[0] !== 1 || k_log[1] !== DacLen + 3) begin
      tests_failed++;
      $display("FAIL b2b_trig: got n=%0d k0=%0d k1=%0d want 2 1 %0d", k_log.size(), k_log[0],
               k_log[1], DacLen + 3);
    end
    tests_run++;
    if (k_log[1] - k_log[0] < SpiWait || addr_log[1] !== 16'h0005 ||
        data_log[1] !== 16'h0011) begin
      tests_failed++;
      $display("FAIL b2b_second: gap=%0d %h/%h want gap>=%0d 0005/0011", k_log[1] - k_log[0],
               addr_log[1], data_log[1], SpiWait);
    end
    tests_run++;
    if (ack_log.size() !== 2 || ack_log[0] !== 1 + DacLen || ack_log[1] !== 2 * DacLen + 3) begin
      tests_failed++;
      $display("FAIL b2b_ack: got n=%0d k0=%0d k1=%0d want 2 %0d %0d", ack_log.size(),
               ack_log[0], ack_log[1], 1 + DacLen, 2 * DacLen + 3);
    end
  endtask

`ifdef CFG_READBACK_EN
  task test_readback();
    rb_force = 1'b1;
    rb_val   = 16'h00AB;
    clear_logs();
    set_req(1'b1, 16'h0014, 16'h00AB);
    run(DacLen + 5, 1'b1, 0);
    tests_run++;
    if (bus.err_out !== 1'b0 || ack_log.size() !== 1) begin
      tests_failed++;
      $display("FAIL rb_match: err=%b acks=%0d want 0 1", bus.err_out, ack_log.size());
    end
    rb_val = 16'h00AA;
    clear_logs();
    set_req(1'b1, 16'h0014, 16'h00AB);
    run(DacLen + 5, 1'b1, 0);
    tests_run++;
    if (bus.err_out !== 1'b1 || ack_log.size() !== 1 || ack_log[0] !== 1 + DacLen) begin
      tests_failed++;
      $display("FAIL rb_mismatch: err=%b acks=%0d k=%0d want 1 1 %0d", bus.err_out,
               ack_log.size(), ack_log[0], 1 + DacLen);
    end
    rb_force = 1'b0;
    clear_logs();
    set_req(1'b1, 16'h0003, 16'h0044);
    run(DacLen + 5, 1'b1, 0);
    tests_run++;
    if (bus.err_out !== 1'b1) begin
      tests_failed++; $display("FAIL rb_sticky: got %b want 1", bus.err_out);
    end
  endtask
`endif

  initial begin
    bus.host_req_in  = 1'b0;
    bus.host_tgt_in  = 1'b0;
    bus.host_addr_in = 16'h0000;
    bus.host_data_in = 16'h0000;
    test_reset();
    test_init();
    test_host_write();
    test_req_during_init();
    test_reset_mid();
    test_back_to_back();
`ifdef CFG_READBACK_EN
    test_readback();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
